// File: rtl/multicycle_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_control: main control FSM that sequences the multicycle datapath.
// Revision 1.0
// ---------------------------------------------------------------------------
module multicycle_control (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  output logic [3:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  pc_source,
  output logic        pc_en,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        i_or_d,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        illegal,
  output logic [31:0] retired
);

  localparam logic [5:0] c_OP_R    = 6'b000000;
  localparam logic [5:0] c_OP_LW   = 6'b100011;
  localparam logic [5:0] c_OP_SW   = 6'b101011;
  localparam logic [5:0] c_OP_BEQ  = 6'b000100;
  localparam logic [5:0] c_OP_BNE  = 6'b000101;
  localparam logic [5:0] c_OP_J    = 6'b000010;
  localparam logic [5:0] c_OP_ADDI = 6'b001000;

  localparam logic [5:0] c_FN_ADD = 6'b100000;
  localparam logic [5:0] c_FN_SUB = 6'b100010;
  localparam logic [5:0] c_FN_AND = 6'b100100;
  localparam logic [5:0] c_FN_OR  = 6'b100101;
  localparam logic [5:0] c_FN_SLT = 6'b101010;
  localparam logic [5:0] c_FN_NOR = 6'b100111;

  localparam logic [3:0] c_ALU_AND = 4'b0000;
  localparam logic [3:0] c_ALU_OR  = 4'b0001;
  localparam logic [3:0] c_ALU_ADD = 4'b0010;
  localparam logic [3:0] c_ALU_SUB = 4'b0110;
  localparam logic [3:0] c_ALU_SLT = 4'b0111;
  localparam logic [3:0] c_ALU_NOR = 4'b1100;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_retired;
  logic [3:0]  r_alu_funct;
  logic        r_is_bne;
  logic        r_is_sw;

  logic        w_funct_ok;
  logic [3:0]  w_funct_op;
  logic        w_retire;
  logic [3:0]  w_alu_op;
  logic        w_src_a;
  logic [1:0]  w_src_b;
  logic [1:0]  w_pc_source;
  logic        w_pc_en;
  logic        w_ir_write;
  logic        w_mem_read;
  logic        w_mem_write;
  logic        w_reg_write;
  logic        w_i_or_d;
  logic        w_mem_to_reg;
  logic        w_reg_dst;
  logic        w_illegal;

  always_comb begin
    w_funct_ok = 1'b1;
    w_funct_op = c_ALU_ADD;
    case (funct)
      c_FN_ADD: w_funct_op = c_ALU_ADD;
      c_FN_SUB: w_funct_op = c_ALU_SUB;
      c_FN_AND: w_funct_op = c_ALU_AND;
      c_FN_OR:  w_funct_op = c_ALU_OR;
      c_FN_SLT: w_funct_op = c_ALU_SLT;
      c_FN_NOR: w_funct_op = c_ALU_NOR;
      default:  w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = S_FETCH;
    w_retire     = 1'b0;
    w_alu_op     = c_ALU_ADD;
    w_src_a      = 1'b0;
    w_src_b      = 2'b00;
    w_pc_source  = 2'b00;
    w_pc_en      = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_i_or_d     = 1'b0;
    w_mem_to_reg = 1'b0;
    w_reg_dst    = 1'b0;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        w_ir_write = 1'b1;
        w_src_b    = 2'b01;
        w_pc_en    = 1'b1;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        w_src_b = 2'b11;
        case (opcode)
          c_OP_LW, c_OP_SW:   w_next = S_MEM_ADDR;
          c_OP_R: begin
            if (w_funct_ok) w_next = S_EXECUTE;
            else            w_illegal = 1'b1;
          end
          c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
          c_OP_J:             w_next = S_JUMP;
          c_OP_ADDI:          w_next = S_ADDI_EX;
          default:            w_illegal = 1'b1;
        endcase
      end
      S_MEM_ADDR: begin
        w_src_a = 1'b1;
        w_src_b = 2'b10;
        w_next  = r_is_sw ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        w_next     = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_retire     = 1'b1;
      end
      S_MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        w_retire    = 1'b1;
      end
      S_EXECUTE: begin
        w_src_a  = 1'b1;
        w_alu_op = r_alu_funct;
        w_next   = S_R_WB;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        w_reg_dst   = 1'b1;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        // zero is live this cycle; bne simply inverts the taken condition
        w_src_a     = 1'b1;
        w_alu_op    = c_ALU_SUB;
        w_pc_source = 2'b01;
        w_pc_en     = zero ^ r_is_bne;
        w_retire    = 1'b1;
      end
      S_JUMP: begin
        w_pc_source = 2'b10;
        w_pc_en     = 1'b1;
        w_retire    = 1'b1;
      end
      S_ADDI_EX: begin
        w_src_a = 1'b1;
        w_src_b = 2'b10;
        w_next  = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_retired   <= 32'd0;
      r_alu_funct <= c_ALU_ADD;
      r_is_bne    <= 1'b0;
      r_is_sw     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + 32'd1;
      if (r_state == S_DECODE) begin
        r_is_bne <= (opcode == c_OP_BNE);
        r_is_sw  <= (opcode == c_OP_SW);
        if (opcode == c_OP_R && w_funct_ok) r_alu_funct <= w_funct_op;
      end
    end
  end

  // Strobes are held low combinationally for the whole time reset is asserted.
  assign pc_en      = w_pc_en     & rst_n;
  assign ir_write   = w_ir_write  & rst_n;
  assign mem_read   = w_mem_read  & rst_n;
  assign mem_write  = w_mem_write & rst_n;
  assign reg_write  = w_reg_write & rst_n;
  assign illegal    = w_illegal   & rst_n;
  assign alu_op     = w_alu_op;
  assign alu_src_a  = w_src_a;
  assign alu_src_b  = w_src_b;
  assign pc_source  = w_pc_source;
  assign i_or_d     = w_i_or_d;
  assign mem_to_reg = w_mem_to_reg;
  assign reg_dst    = w_reg_dst;
  assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// tb_multicycle_control: table-driven per-cycle checks of the control FSM.
module tb_multicycle_control;

  localparam logic [5:0] c_R    = 6'b000000;
  localparam logic [5:0] c_LW   = 6'b100011;
  localparam logic [5:0] c_SW   = 6'b101011;
  localparam logic [5:0] c_BEQ  = 6'b000100;
  localparam logic [5:0] c_BNE  = 6'b000101;
  localparam logic [5:0] c_J    = 6'b000010;
  localparam logic [5:0] c_ADDI = 6'b001000;
  localparam logic [5:0] c_JUNK = 6'b111111;

  // {pc_en,ir_write,mem_read,mem_write,reg_write,i_or_d,mem_to_reg,reg_dst,illegal,src_a,src_b,pc_source,alu_op}
  localparam logic [17:0] E_RST      = {9'b000000000, 1'b0, 2'b01, 2'b00, 4'b0010};
  localparam logic [17:0] E_FETCH    = {9'b111000000, 1'b0, 2'b01, 2'b00, 4'b0010};
  localparam logic [17:0] E_DECODE   = {9'b000000000, 1'b0, 2'b11, 2'b00, 4'b0010};
  localparam logic [17:0] E_DEC_ILL  = {9'b000000001, 1'b0, 2'b11, 2'b00, 4'b0010};
  localparam logic [17:0] E_MEM_ADDR = {9'b000000000, 1'b1, 2'b10, 2'b00, 4'b0010};
  localparam logic [17:0] E_MEM_READ = {9'b001001000, 1'b0, 2'b00, 2'b00, 4'b0010};
  localparam logic [17:0] E_MR_RST   = {9'b000001000, 1'b0, 2'b00, 2'b00, 4'b0010};
  localparam logic [17:0] E_MEM_WB   = {9'b000010100, 1'b0, 2'b00, 2'b00, 4'b0010};
  localparam logic [17:0] E_MEM_WR   = {9'b000101000, 1'b0, 2'b00, 2'b00, 4'b0010};
  localparam logic [17:0] E_R_WB     = {9'b000010010, 1'b0, 2'b00, 2'b00, 4'b0010};
  localparam logic [17:0] E_JUMP     = {9'b100000000, 1'b0, 2'b00, 2'b10, 4'b0010};
  localparam logic [17:0] E_ADDI_EX  = {9'b000000000, 1'b1, 2'b10, 2'b00, 4'b0010};
  localparam logic [17:0] E_ADDI_WB  = {9'b000010000, 1'b0, 2'b00, 2'b00, 4'b0010};

  typedef struct {
    bit          rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    bit          z;
    bit          chk;
    logic [17:0] exp;
    logic [31:0] ret;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic [3:0]  alu_op;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_source;
  logic        pc_en, ir_write, mem_read, mem_write, reg_write;
  logic        i_or_d, mem_to_reg, reg_dst, illegal;
  logic [31:0] retired;
  logic [17:0] got;

  vec_t        tbl[$];
  logic [31:0] er;
  int          n_pass;
  int          n_total;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_source(pc_source), .pc_en(pc_en), .ir_write(ir_write),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .illegal(illegal), .retired(retired)
  );

  assign got = {pc_en, ir_write, mem_read, mem_write, reg_write, i_or_d,
                mem_to_reg, reg_dst, illegal, alu_src_a, alu_src_b, pc_source, alu_op};

  initial clk = 1'b1;
  always #5 clk = ~clk;

  function automatic logic [17:0] exec_v(input logic [3:0] op);
    return {9'b000000000, 1'b1, 2'b00, 2'b00, op};
  endfunction

  function automatic logic [17:0] branch_v(input logic pe);
    return {pe, 8'b00000000, 1'b1, 2'b00, 2'b01, 4'b0110};
  endfunction

  task automatic push(input bit r, input logic [5:0] op, input logic [5:0] fn,
                      input bit z, input bit chk, input logic [17:0] e);
    vec_t v;
    v.rst = r; v.op = op; v.fn = fn; v.z = z; v.chk = chk; v.exp = e; v.ret = er;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
  endtask

  task automatic r_type(input logic [5:0] fn, input logic [3:0] aop);
    push(1, c_JUNK, 6'h00, 0, 1, E_FETCH);
    push(1, c_R,    fn,    0, 1, E_DECODE);
    push(1, c_LW,   6'h00, 0, 1, exec_v(aop));
    push(1, c_SW,   6'h00, 0, 1, E_R_WB);
    er = er + 1;
  endtask

  task automatic branch(input logic [5:0] op, input bit z, input bit taken);
    push(1, c_JUNK, 6'h00, !z, 1, E_FETCH);
    push(1, op,     6'h00, !z, 1, E_DECODE);
    push(1, c_J,    6'h00, z,  1, branch_v(taken));
    er = er + 1;
  endtask

  task automatic addi();
    push(1, c_JUNK, 6'h00, 0, 1, E_FETCH);
    push(1, c_ADDI, 6'h00, 0, 1, E_DECODE);
    push(1, c_JUNK, 6'h00, 0, 1, E_ADDI_EX);
    push(1, c_JUNK, 6'h00, 0, 1, E_ADDI_WB);
    er = er + 1;
  endtask

  initial begin
    n_pass = 0; n_total = 0; er = 32'd0;
    rst_n = 1'b0; opcode = c_LW; funct = 6'h00; zero = 1'b0;

    // reset held three cycles; the first precedes any clock edge
    push(0, c_LW, 6'h00, 0, 0, E_RST);
    push(0, c_LW, 6'h00, 0, 1, E_RST);
    push(0, c_LW, 6'h00, 0, 1, E_RST);
    r_type(6'b100010, 4'b0110);
    // lw
    push(1, c_JUNK, 6'h00, 0, 1, E_FETCH);
    push(1, c_LW,   6'h00, 0, 1, E_DECODE);
    push(1, c_SW,   6'h00, 0, 1, E_MEM_ADDR);
    push(1, c_SW,   6'h00, 0, 1, E_MEM_READ);
    push(1, c_JUNK, 6'h00, 0, 1, E_MEM_WB);
    er = er + 1;
    // sw
    push(1, c_JUNK, 6'h00, 0, 1, E_FETCH);
    push(1, c_SW,   6'h00, 0, 1, E_DECODE);
    push(1, c_LW,   6'h00, 0, 1, E_MEM_ADDR);
    push(1, c_LW,   6'h00, 0, 1, E_MEM_WR);
    er = er + 1;
    r_type(6'b100100, 4'b0000);
    r_type(6'b100101, 4'b0001);
    r_type(6'b100000, 4'b0010);
    r_type(6'b101010, 4'b0111);
    r_type(6'b100111, 4'b1100);
    branch(c_BEQ, 1, 1);
    branch(c_BEQ, 0, 0);
    branch(c_BNE, 0, 1);
    branch(c_BNE, 1, 0);
    // j
    push(1, c_JUNK, 6'h00, 0, 1, E_FETCH);
    push(1, c_J,    6'h00, 0, 1, E_DECODE);
    push(1, c_JUNK, 6'h00, 0, 1, E_JUMP);
    er = er + 1;
    addi();
    // illegal opcode, then R-type with an undefined funct
    push(1, c_JUNK, 6'h00,     0, 1, E_FETCH);
    push(1, c_JUNK, 6'h00,     0, 1, E_DEC_ILL);
    push(1, c_JUNK, 6'h00,     0, 1, E_FETCH);
    push(1, c_R,    6'b000000, 0, 1, E_DEC_ILL);
    // lw aborted by reset during MEM_READ
    push(1, c_JUNK, 6'h00, 0, 1, E_FETCH);
    push(1, c_LW,   6'h00, 0, 1, E_DECODE);
    push(1, c_JUNK, 6'h00, 0, 1, E_MEM_ADDR);
    push(0, c_JUNK, 6'h00, 0, 1, E_MR_RST);
    er = 32'd0;
    addi();

    for (int i = 0; i < tbl.size(); i++) begin
      rst_n  = tbl[i].rst;
      opcode = tbl[i].op;
      funct  = tbl[i].fn;
      zero   = tbl[i].z;
      @(negedge clk);
      if (tbl[i].chk) begin
        check("ctrl", i, {14'd0, got}, {14'd0, tbl[i].exp});
        check("retired", i, retired, tbl[i].ret);
      end
      @(posedge clk); #1;
    end

    // retired wraps: preload all-ones during FETCH, then retire one j
    rst_n = 1'b1; opcode = c_JUNK; funct = 6'h00; zero = 1'b0;
    force dut.r_retired = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.r_retired;
    @(posedge clk); #1;
    opcode = c_J;
    @(negedge clk);
    check("wrap_decode", 1000, {14'd0, got}, {14'd0, E_DECODE});
    @(posedge clk); #1;
    opcode = c_JUNK;
    @(negedge clk);
    check("wrap_jump", 1001, {14'd0, got}, {14'd0, E_JUMP});
    check("wrap_pre", 1001, retired, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    @(negedge clk);
    check("wrap_fetch", 1002, {14'd0, got}, {14'd0, E_FETCH});
    check("wrap_zero", 1002, retired, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
